// File: rtl/crc_32_sched_pkg.sv
// -----------------------------------------------------------------------------
// crc_32_sched_pkg
// Shared constants and types for the multi-request CRC-32 scheduler.
//   CRC_INIT        seed for a fresh packet
//   CRC_XOROUT      final inversion applied to a completed packet CRC
//   CRC_WORD_WIDTH  width of one datapath word in bits
//   stream_state_e  per-stream packet state (IDLE, ACCUM, DONE)
// -----------------------------------------------------------------------------
package crc_32_sched_pkg;

  localparam logic [31:0] CRC_INIT       = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT     = 32'hFFFFFFFF;
  localparam int          CRC_WORD_WIDTH = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } stream_state_e;

endpackage

// File: rtl/crc_32_rr_multi_grant.sv
// -----------------------------------------------------------------------------
// crc_32_rr_multi_grant
// Combinational round-robin picker that grants up to INST_COUNT of REQ_COUNT
// eligible requesters per cycle. The scan starts at rr_ptr_i and wraps.
// Ports:
//   eligible_i  requester eligibility mask
//   rr_ptr_i    current round-robin start index
//   grant_o     granted requesters (at most INST_COUNT bits set)
//   next_ptr_o  index after the last granted requester, or rr_ptr_i if none
// -----------------------------------------------------------------------------
module crc_32_rr_multi_grant #(
  parameter  int REQ_COUNT  = 4,
  parameter  int INST_COUNT = 2,
  localparam int PTR_WIDTH  = $clog2(REQ_COUNT)
) (
  input  logic [REQ_COUNT-1:0] eligible_i,
  input  logic [PTR_WIDTH-1:0] rr_ptr_i,
  output logic [REQ_COUNT-1:0] grant_o,
  output logic [PTR_WIDTH-1:0] next_ptr_o
);

  // Walk the requesters in round-robin order from the pointer and take the
  // first INST_COUNT eligible ones. The next pointer lands just past the
  // last one taken so the skipped streams are first in line next cycle.
  always_comb begin
    int                   granted;
    logic [PTR_WIDTH-1:0] idx;
    grant_o    = '0;
    next_ptr_o = rr_ptr_i;
    granted    = 0;
    idx        = '0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      idx = PTR_WIDTH'((int'(rr_ptr_i) + k) % REQ_COUNT);
      if (eligible_i[idx] && (granted < INST_COUNT)) begin
        grant_o[idx] = 1'b1;
        granted      = granted + 1;
        next_ptr_o   = PTR_WIDTH'((int'(idx) + 1) % REQ_COUNT);
      end
    end
  end

endmodule

// File: rtl/crc_32_req_scheduler.sv
// -----------------------------------------------------------------------------
// crc_32_req_scheduler
// Sequencing and arbitration front-end for a shared combinational CRC-32
// datapath. Keeps a running CRC per stream, grants up to INST_COUNT streams
// per cycle round-robin, masks the datapath word valids to the granted
// streams, and returns each finished CRC through a per-stream handshake.
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   REQ_VALID/READY/SOP/EOP      per-stream beat handshake and framing
//   REQ_WORD_VALID, REQ_DATA     per-word valids and beat data
//   RES_VALID/READY, RES_CRC     per-stream final CRC handshake
//   DP_CRC_IN/VALID/DATA         drive to the CRC datapath
//   DP_CRC_OUT                   CRC result from the datapath
// Optional build macro CRC_32_SCHED_ERR_CNT_EN adds:
//   ERR_COUNT  saturating count of framing anomalies
//   ERR_CLR    clears ERR_COUNT
// -----------------------------------------------------------------------------
module crc_32_req_scheduler
  import crc_32_sched_pkg::*;
#(
  parameter  int REQ_COUNT      = 4,
  parameter  int INST_COUNT     = 2,
  parameter  int PARALLEL_DEPTH = 2,
  localparam int PTR_WIDTH      = $clog2(REQ_COUNT)
) (
  input  logic                                           CLK,
  input  logic                                           RST,
  input  logic [REQ_COUNT-1:0]                           REQ_VALID,
  output logic [REQ_COUNT-1:0]                           REQ_READY,
  input  logic [REQ_COUNT-1:0]                           REQ_SOP,
  input  logic [REQ_COUNT-1:0]                           REQ_EOP,
  input  logic [REQ_COUNT*PARALLEL_DEPTH-1:0]            REQ_WORD_VALID,
  input  logic [REQ_COUNT*PARALLEL_DEPTH*CRC_WORD_WIDTH-1:0] REQ_DATA,
  output logic [REQ_COUNT-1:0]                           RES_VALID,
  input  logic [REQ_COUNT-1:0]                           RES_READY,
  output logic [REQ_COUNT*32-1:0]                        RES_CRC,
  output logic [REQ_COUNT*32-1:0]                        DP_CRC_IN,
  output logic [REQ_COUNT*PARALLEL_DEPTH-1:0]            DP_VALID,
  output logic [REQ_COUNT*PARALLEL_DEPTH*CRC_WORD_WIDTH-1:0] DP_DATA,
  input  logic [REQ_COUNT*32-1:0]                        DP_CRC_OUT
`ifdef CRC_32_SCHED_ERR_CNT_EN
  ,
  output logic [15:0]                                    ERR_COUNT,
  input  logic                                           ERR_CLR
`endif
);

  logic [REQ_COUNT-1:0] eligible;
  logic [REQ_COUNT-1:0] grant;
  logic [REQ_COUNT-1:0] accept;
  logic [PTR_WIDTH-1:0] rrPtr_q;
  logic [PTR_WIDTH-1:0] rrPtr_d;

  crc_32_rr_multi_grant #(
    .REQ_COUNT (REQ_COUNT),
    .INST_COUNT(INST_COUNT)
  ) uPicker (
    .eligible_i(eligible),
    .rr_ptr_i  (rrPtr_q),
    .grant_o   (grant),
    .next_ptr_o(rrPtr_d)
  );

  // Nothing is granted while reset is held, so no beat can slip through.
  assign REQ_READY = grant & {REQ_COUNT{~RST}};
  assign accept    = REQ_VALID & REQ_READY;
  assign DP_DATA   = REQ_DATA;

  // The picker already returns the held pointer when nothing is granted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rrPtr_q <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end

  for (genvar g = 0; g < REQ_COUNT; g++) begin : gStream
    stream_state_e state_q;
    logic [31:0]   crc_q;
    logic [31:0]   resCrc_q;
    logic          resValid_q;

    // A beat with no valid words would make no progress, so it is never
    // granted; a stream holding an unread result is parked until drained.
    assign eligible[g] = REQ_VALID[g]
                       & (|REQ_WORD_VALID[g*PARALLEL_DEPTH +: PARALLEL_DEPTH])
                       & (state_q != DONE);

    assign DP_VALID[g*PARALLEL_DEPTH +: PARALLEL_DEPTH] =
      REQ_WORD_VALID[g*PARALLEL_DEPTH +: PARALLEL_DEPTH] & {PARALLEL_DEPTH{REQ_READY[g]}};

    // An SOP or any beat arriving in IDLE starts from the seed, which also
    // throws away a partial CRC when a packet is restarted mid-stream.
    assign DP_CRC_IN[g*32 +: 32] = (REQ_SOP[g] || (state_q == IDLE)) ? CRC_INIT : crc_q;

    assign RES_VALID[g]        = resValid_q;
    assign RES_CRC[g*32 +: 32] = resCrc_q;

    // Per-stream packet FSM. An accepted beat folds the datapath result into
    // the running CRC; the EOP beat also publishes the inverted CRC. DONE
    // only leaves on the result handshake, so the stream cannot be granted
    // again until the following cycle.
    always_ff @(posedge CLK) begin
      if (RST) begin
        state_q    <= IDLE;
        crc_q      <= CRC_INIT;
        resCrc_q   <= '0;
        resValid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE, ACCUM: begin
            if (accept[g]) begin
              crc_q <= DP_CRC_OUT[g*32 +: 32];
              if (REQ_EOP[g]) begin
                state_q    <= DONE;
                resCrc_q   <= DP_CRC_OUT[g*32 +: 32] ^ CRC_XOROUT;
                resValid_q <= 1'b1;
              end else begin
                state_q <= ACCUM;
              end
            end
          end
          DONE: begin
            if (resValid_q && RES_READY[g]) begin
              state_q    <= IDLE;
              resValid_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef CRC_32_SCHED_ERR_CNT_EN
  logic [REQ_COUNT-1:0] errEvent;
  logic [15:0]          errCount_q;
  logic [16:0]          errSum;

  // Framing anomalies: a continuation beat with no packet open, or a new
  // packet started on top of an unfinished one.
  for (genvar e = 0; e < REQ_COUNT; e++) begin : gErr
    assign errEvent[e] = accept[e]
                       & (((gStream[e].state_q == IDLE)  & ~REQ_SOP[e])
                        | ((gStream[e].state_q == ACCUM) &  REQ_SOP[e]));
  end

  assign errSum    = {1'b0, errCount_q} + 17'($countones(errEvent));
  assign ERR_COUNT = errCount_q;

  // Saturating accumulator; a clear request overrides any same-cycle events.
  always_ff @(posedge CLK) begin
    if (RST || ERR_CLR) begin
      errCount_q <= '0;
    end else begin
      errCount_q <= errSum[16] ? 16'hFFFF : errSum[15:0];
    end
  end
`endif

endmodule

// File: doc/crc_32_req_scheduler.md
Name: crc_32_req_scheduler

Overview:
Sequencing and arbitration front-end for the combinational multi-request CRC-32 datapath. REQ_COUNT packet streams share INST_COUNT parallel CRC engines. The block does four things:
- Holds the running CRC per stream.
- Grants up to INST_COUNT streams per cycle, round-robin.
- Masks the datapath inputs so only granted streams are processed.
- Registers the final CRC and returns it through a per-stream result handshake.

Parameters:
REQ_COUNT, 4, number of requester streams (>=2).
INST_COUNT, 2, datapath engines; max grants per cycle (1..REQ_COUNT).
PARALLEL_DEPTH, 2, 48-bit words per beat.
PTR_WIDTH, $clog2(REQ_COUNT), derived; do not set.

Ports:
CLK  in  1  clock, all logic rising-edge.
RST  in  1  synchronous active-high reset.
REQ_VALID  in  REQ_COUNT  beat offered per stream.
REQ_READY  out  REQ_COUNT  beat granted this cycle (combinational).
REQ_SOP  in  REQ_COUNT  first beat of packet.
REQ_EOP  in  REQ_COUNT  last beat of packet.
REQ_WORD_VALID  in  REQ_COUNT*PARALLEL_DEPTH  per-word valid, word 0 first.
REQ_DATA  in  REQ_COUNT*PARALLEL_DEPTH*48  beat data.
RES_VALID  out  REQ_COUNT  final CRC available.
RES_READY  in  REQ_COUNT  result consumed.
RES_CRC  out  REQ_COUNT*32  final CRC per stream.
DP_CRC_IN  out  REQ_COUNT*32  to datapath CRC_IN.
DP_VALID  out  REQ_COUNT*PARALLEL_DEPTH  to datapath VALID (masked).
DP_DATA  out  REQ_COUNT*PARALLEL_DEPTH*48  to datapath DATA (pass-through).
DP_CRC_OUT  in  REQ_COUNT*32  from datapath CRC_OUT.

Behaviour:
- Clocking and reset: one clock CLK; RST synchronous, active-high.
- Reset values:
  - RES_VALID=0, RES_CRC=0.
  - Per-stream state IDLE, crc_reg=32'hFFFFFFFF, rr_ptr=0.
  - REQ_READY forced 0 while RST=1.
- Per-stream FSM:
  - IDLE --accepted beat, EOP=0--> ACCUM.
  - IDLE/ACCUM --accepted beat, EOP=1--> DONE.
  - ACCUM --accepted beat, EOP=0--> ACCUM.
  - DONE --RES_VALID&RES_READY--> IDLE.
- Eligibility: stream i is eligible when REQ_VALID[i] & |REQ_WORD_VALID[i] & state!=DONE. A zero-word beat is never granted; the stream stalls until its word valids change.
- Grant selection:
  - Scan indices rr_ptr, rr_ptr+1, ... with wrap modulo REQ_COUNT.
  - Grant the first min(INST_COUNT, #eligible) eligible streams.
  - REQ_READY = grant. Acceptance = REQ_VALID & REQ_READY.
- Pointer update: if >=1 grant, rr_ptr <= (highest-scanned granted index + 1) mod REQ_COUNT. Otherwise rr_ptr holds.
- Datapath drive:
  - DP_VALID = REQ_WORD_VALID AND-ed with grant replicated per word.
  - DP_CRC_IN[i] = (REQ_SOP[i] | state==IDLE) ? 32'hFFFFFFFF : crc_reg[i].
  - DP_DATA = REQ_DATA.
  - At most INST_COUNT streams are active, so the datapath processes every granted stream.
- Update on acceptance:
  - crc_reg[i] <= DP_CRC_OUT[i].
  - If EOP: RES_CRC[i] <= DP_CRC_OUT[i] ^ 32'hFFFFFFFF and RES_VALID[i] <= 1.
  - Latency: beat accepted in cycle N → RES_VALID visible in cycle N+1.
- Result hold: RES_CRC/RES_VALID hold until RES_READY. Deassertion happens at the next edge. The stream becomes eligible again in the cycle after the handshake, never in the same cycle.
- Boundary cases:
  - SOP in ACCUM: restarts the packet from init; previous partial CRC is discarded.
  - SOP=EOP=1: single-beat packet, IDLE→DONE.
  - Non-SOP beat in IDLE: treated as SOP (init value used).
  - REQ_COUNT eligible, INST_COUNT<REQ_COUNT: each stream is granted at least once every ceil(REQ_COUNT/INST_COUNT) cycles.
  - RST mid-packet: all partial CRCs and pending results are lost, and the state returns to reset values.

Optional Feature:
CRC_32_SCHED_ERR_CNT_EN.
- Defined: adds output ERR_COUNT [15:0] and input ERR_CLR [1].
  - ERR_COUNT increments, saturating at 16'hFFFF, once per cycle per event: an accepted non-SOP beat in IDLE, or an SOP beat in ACCUM. Two events in one cycle add 2.
  - ERR_CLR=1 zeroes it; clear wins over increment.
  - Reset value 0.
- Undefined: ports absent, no counter logic. Functional behaviour is identical.

Decomposition:
- Package crc_32_sched_pkg:
  - CRC_INIT=32'hFFFFFFFF, CRC_XOROUT=32'hFFFFFFFF, CRC_WORD_WIDTH=48.
  - State enum {IDLE, ACCUM, DONE}.
- One sub-module, crc_32_rr_multi_grant: combinational round-robin N-of-M picker.
  - Inputs: eligible mask, rr_ptr.
  - Outputs: grant mask, next pointer.
  - Parameters: REQ_COUNT, INST_COUNT.

Test Plan:
1. Reset, then no requests → REQ_READY=0, RES_VALID=0, DP_VALID=0, rr_ptr=0 for 10 cycles.
2. REQ_COUNT=4, INST_COUNT=2, all four streams hold REQ_VALID with all word valids → grants 4'b0011, 4'b1100, 4'b0011…; rr_ptr sequence 0,2,0.
3. Stream 1: single-beat packet (SOP=EOP=1), one word 48'h313233343536 ("123456") → RES_VALID[1]=1 next cycle. RES_CRC[1] equals the reflected CRC-32 golden model of those 6 bytes (32'h0972D361). Holds until RES_READY[1].
4. Stream 2: 3-beat packet with RES_READY=0 → after EOP, REQ_READY[2]=0 for the next offered packet until RES_READY[2]=1. Grant resumes exactly one cycle after the handshake.
5. Stream 0: SOP mid-packet after 2 beats → final CRC equals golden CRC of the new packet only. With CRC_32_SCHED_ERR_CNT_EN, ERR_COUNT=1.
6. Stream 3: RST asserted during beat 2 of 4 → next cycle RES_VALID=0, state IDLE. A fresh packet after reset yields the golden CRC.
